// File: rtl/mix_columns_seq.sv
// mix_columns_seq -- column-serial AES MixColumns / InvMixColumns stage.
//
// One 4x4 state matrix is accepted at a time and mixed one column per clock
// (four cycles), then held until the downstream stage takes it. A bypass
// matrix, used in the final AES round, goes straight to the output unchanged.
//
// Parameters
//   INVERSE       0 = forward MixColumns, 1 = InvMixColumns
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   in_valid      upstream matrix valid
//   in_ready      block can accept a matrix this cycle
//   in_bypass     pass matrix through unmixed (sampled only at accept)
//   state_matrix  input bytes, [row][col]
//   out_valid     mixed_matrix holds a finished result
//   out_ready     downstream accepts the result
//   mixed_matrix  result bytes, [row][col]
//   busy          high while columns are being mixed
module mix_columns_seq #(
  parameter bit INVERSE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_bypass,
  input  logic [0:3][0:3][7:0]   state_matrix,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [0:3][0:3][7:0]   mixed_matrix,
  output logic                   busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                 r_state;
  logic [1:0]             r_col;
  logic [0:3][0:3][7:0]   r_work;

  logic                   w_accept;
  logic [0:3][7:0]        w_col_in;
  logic [0:3][7:0]        w_col_out;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul2(input logic [7:0] b);
    mul2 = xtime(b);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] b);
    mul3 = xtime(b) ^ b;
  endfunction

  // 9, 11, 13, 14 built from the x^3, x^2, x partial products.
  function automatic logic [7:0] mul9(input logic [7:0] b);
    mul9 = xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] b);
    mulb = xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] b);
    muld = xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] b);
    mule = xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  function automatic logic [0:3][7:0] fwd_col(input logic [0:3][7:0] a);
    fwd_col[0] = mul2(a[0]) ^ mul3(a[1]) ^ a[2]       ^ a[3];
    fwd_col[1] = a[0]       ^ mul2(a[1]) ^ mul3(a[2]) ^ a[3];
    fwd_col[2] = a[0]       ^ a[1]       ^ mul2(a[2]) ^ mul3(a[3]);
    fwd_col[3] = mul3(a[0]) ^ a[1]       ^ a[2]       ^ mul2(a[3]);
  endfunction

  function automatic logic [0:3][7:0] inv_col(input logic [0:3][7:0] a);
    inv_col[0] = mule(a[0]) ^ mulb(a[1]) ^ muld(a[2]) ^ mul9(a[3]);
    inv_col[1] = mul9(a[0]) ^ mule(a[1]) ^ mulb(a[2]) ^ muld(a[3]);
    inv_col[2] = muld(a[0]) ^ mul9(a[1]) ^ mule(a[2]) ^ mulb(a[3]);
    inv_col[3] = mulb(a[0]) ^ muld(a[1]) ^ mul9(a[2]) ^ mule(a[3]);
  endfunction

  // A DONE result may be handed off and a new matrix taken on the same edge.
  assign in_ready     = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept     = in_valid && in_ready;
  assign out_valid    = (r_state == S_DONE);
  assign busy         = (r_state == S_COMPUTE);
  assign mixed_matrix = r_work;

  // Select the column currently being processed and transform it.
  always_comb begin
    w_col_in  = '0;
    w_col_out = '0;
    for (int r = 0; r < 4; r++) begin
      w_col_in[r] = r_work[r][r_col];
    end
    if (INVERSE) begin
      w_col_out = inv_col(w_col_in);
    end else begin
      w_col_out = fwd_col(w_col_in);
    end
  end

  // Control FSM, column counter and working register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_col   <= 2'd0;
      r_work  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_work  <= state_matrix;
            r_col   <= 2'd0;
            r_state <= in_bypass ? S_DONE : S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          for (int r = 0; r < 4; r++) begin
            r_work[r][r_col] <= w_col_out[r];
          end
          r_col <= r_col + 2'd1;
          if (r_col == 2'd3) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (w_accept) begin
            r_work  <= state_matrix;
            r_col   <= 2'd0;
            r_state <= in_bypass ? S_DONE : S_COMPUTE;
          end else if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_col   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Testbench for mix_columns_seq: a forward and an inverse instance share the
// control signals; each gets its own input matrix.
module tb_mix_columns_seq;

  typedef logic [0:3][0:3][7:0] mat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_bypass = 1'b0;
  logic out_ready = 1'b1;
  mat_t sm_f = '0;
  mat_t sm_i = '0;
  logic rdy_f, ov_f, busy_f, rdy_i, ov_i, busy_i;
  mat_t mm_f, mm_i;

  int n_cmp = 0;
  int n_fail = 0;

  mat_t F_IN, F_OUT, R_IN, R_OUT, BP;
  mat_t qf[$];
  mat_t qi[$];

  always #5 clk = ~clk;

  mix_columns_seq #(.INVERSE(1'b0)) dut_f (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_f),
    .in_bypass(in_bypass), .state_matrix(sm_f), .out_valid(ov_f),
    .out_ready(out_ready), .mixed_matrix(mm_f), .busy(busy_f)
  );

  mix_columns_seq #(.INVERSE(1'b1)) dut_i (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_i),
    .in_bypass(in_bypass), .state_matrix(sm_i), .out_valid(ov_i),
    .out_ready(out_ready), .mixed_matrix(mm_i), .busy(busy_i)
  );

  // Columns given as {row0,row1,row2,row3}.
  function automatic mat_t mk(input logic [31:0] c0, input logic [31:0] c1,
                              input logic [31:0] c2, input logic [31:0] c3);
    logic [31:0] cs [4];
    mat_t m;
    cs[0] = c0; cs[1] = c1; cs[2] = c2; cs[3] = c3;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = cs[c][31-8*r -: 8];
    return m;
  endfunction

  // Generic shift-and-add GF(2^8) multiply for the reference model.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic mat_t model(input mat_t m, input bit inv);
    logic [7:0] co [4];
    mat_t o;
    if (inv) co = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     co = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        o[r][c] = 8'h00;
        for (int k = 0; k < 4; k++)
          o[r][c] = o[r][c] ^ gmul(m[k][c], co[(k - r + 4) % 4]);
      end
    return o;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = 8'($urandom);
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({ov_f, busy_f, rdy_f, ov_i, busy_i, rdy_i} !== 6'b001001) begin
      $display("FAIL reset_flags: got %b want 001001", {ov_f, busy_f, rdy_f, ov_i, busy_i, rdy_i});
      n_fail++;
    end
    n_cmp++;
    if ({mm_f, mm_i} !== 256'h0) begin
      $display("FAIL reset_matrix: got %h %h want 0", mm_f, mm_i);
      n_fail++;
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if ({ov_f, busy_f, rdy_f, mm_f} !== {3'b001, 128'h0}) begin
      $display("FAIL post_reset_idle: got %b %h want 001 0", {ov_f, busy_f, rdy_f}, mm_f);
      n_fail++;
    end
  endtask

  task automatic test_forward_inverse();
    in_valid = 1'b1; in_bypass = 1'b0; out_ready = 1'b1;
    sm_f = F_IN; sm_i = F_OUT;
    #1;
    n_cmp++;
    if ({rdy_f, rdy_i} !== 2'b11) begin
      $display("FAIL idle_ready: got %b want 11", {rdy_f, rdy_i});
      n_fail++;
    end
    step();
    in_valid = 1'b0; sm_f = '0; sm_i = '0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({busy_f, ov_f, rdy_f, busy_i, ov_i} !== 5'b10010) begin
        $display("FAIL compute_flags_%0d: got %b want 10010", k, {busy_f, ov_f, rdy_f, busy_i, ov_i});
        n_fail++;
      end
      step();
    end
    n_cmp++;
    if ({ov_f, busy_f, ov_i, busy_i} !== 4'b1010) begin
      $display("FAIL done_flags: got %b want 1010", {ov_f, busy_f, ov_i, busy_i});
      n_fail++;
    end
    n_cmp++;
    if (mm_f !== F_OUT) begin
      $display("FAIL forward_vector: got %h want %h", mm_f, F_OUT);
      n_fail++;
    end
    n_cmp++;
    if (mm_i !== F_IN) begin
      $display("FAIL inverse_vector: got %h want %h", mm_i, F_IN);
      n_fail++;
    end
    step();
    n_cmp++;
    if ({ov_f, rdy_f} !== 2'b01) begin
      $display("FAIL return_idle: got %b want 01", {ov_f, rdy_f});
      n_fail++;
    end
  endtask

  task automatic test_bypass();
    in_valid = 1'b1; in_bypass = 1'b1; out_ready = 1'b1;
    sm_f = BP; sm_i = BP;
    step();
    in_valid = 1'b0; in_bypass = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if ({ov_f, busy_f, ov_i, busy_i} !== 4'b1010) begin
      $display("FAIL bypass_flags: got %b want 1010", {ov_f, busy_f, ov_i, busy_i});
      n_fail++;
    end
    n_cmp++;
    if ({mm_f, mm_i} !== {BP, BP}) begin
      $display("FAIL bypass_data: got %h %h want %h", mm_f, mm_i, BP);
      n_fail++;
    end
    for (int k = 0; k < 2; k++) begin
      in_bypass = ~in_bypass;
      step();
    end
    n_cmp++;
    if ({ov_f, busy_f, mm_f} !== {2'b10, BP}) begin
      $display("FAIL bypass_hold: got %b %h want 10 %h", {ov_f, busy_f}, mm_f, BP);
      n_fail++;
    end
    out_ready = 1'b1;
    step();
    n_cmp++;
    if (ov_f !== 1'b0) begin
      $display("FAIL bypass_release: got %b want 0", ov_f);
      n_fail++;
    end
  endtask

  task automatic test_stall_back_to_back();
    in_valid = 1'b1; in_bypass = 1'b0; out_ready = 1'b0;
    sm_f = F_IN; sm_i = F_OUT;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_bypass = 1'b1; sm_f = R_IN; sm_i = R_OUT;
      #1;
      n_cmp++;
      if ({ov_f, rdy_f, busy_f, mm_f, mm_i} !== {3'b100, F_OUT, F_IN}) begin
        $display("FAIL stall_%0d: got %b %h %h want 100 %h %h", k, {ov_f, rdy_f, busy_f}, mm_f, mm_i, F_OUT, F_IN);
        n_fail++;
      end
      step();
    end
    out_ready = 1'b1; in_valid = 1'b1; in_bypass = 1'b0;
    #1;
    n_cmp++;
    if (rdy_f !== 1'b1) begin
      $display("FAIL b2b_ready: got %b want 1", rdy_f);
      n_fail++;
    end
    step();
    in_valid = 1'b0;
    n_cmp++;
    if ({busy_f, ov_f} !== 2'b10) begin
      $display("FAIL b2b_accept: got %b want 10", {busy_f, ov_f});
      n_fail++;
    end
    repeat (4) step();
    n_cmp++;
    if ({ov_f, mm_f, mm_i} !== {1'b1, R_OUT, R_IN}) begin
      $display("FAIL b2b_result: got %b %h %h want 1 %h %h", ov_f, mm_f, mm_i, R_OUT, R_IN);
      n_fail++;
    end
    step();
  endtask

  task automatic test_reset_mid_compute();
    in_valid = 1'b1; in_bypass = 1'b0; out_ready = 1'b1;
    sm_f = F_IN; sm_i = F_OUT;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    n_cmp++;
    if (busy_f !== 1'b1) begin
      $display("FAIL mid_busy: got %b want 1", busy_f);
      n_fail++;
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({ov_f, busy_f, rdy_f, mm_f, mm_i} !== {3'b001, 256'h0}) begin
      $display("FAIL async_reset: got %b %h %h want 001 0", {ov_f, busy_f, rdy_f}, mm_f, mm_i);
      n_fail++;
    end
    rst = 1'b0;
    #1;
    in_valid = 1'b1; sm_f = R_IN; sm_i = R_OUT;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (ov_f !== 1'b0) begin
      $display("FAIL no_partial: got %b want 0", ov_f);
      n_fail++;
    end
    step();
    n_cmp++;
    if ({ov_f, mm_f, mm_i} !== {1'b1, R_OUT, R_IN}) begin
      $display("FAIL after_reset_vector: got %b %h %h want 1 %h %h", ov_f, mm_f, mm_i, R_OUT, R_IN);
      n_fail++;
    end
    step();
  endtask

  task automatic test_random_stream();
    int n_acc = 0;
    int n_out = 0;
    int cyc = 0;
    while (n_acc < 1000 && cyc < 60000) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_bypass = 1'($urandom_range(0, 1));
      sm_f = rand_mat();
      sm_i = rand_mat();
      #1;
      if (ov_f && out_ready) begin
        n_cmp++;
        if (qf.size() == 0 || qi.size() == 0) begin
          $display("FAIL rand_unexpected_output: got out_valid=1 want no pending result");
          n_fail++;
        end else begin
          mat_t ef = qf.pop_front();
          mat_t ei = qi.pop_front();
          if ({mm_f, mm_i} !== {ef, ei}) begin
            $display("FAIL rand_out_%0d: got %h %h want %h %h", n_out, mm_f, mm_i, ef, ei);
            n_fail++;
          end
        end
        n_out++;
      end
      if (in_valid && rdy_f) begin
        qf.push_back(in_bypass ? sm_f : model(sm_f, 1'b0));
        qi.push_back(in_bypass ? sm_i : model(sm_i, 1'b1));
        n_acc++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 20 && qf.size() != 0; k++) begin
      #1;
      if (ov_f) begin
        mat_t ef = qf.pop_front();
        mat_t ei = qi.pop_front();
        n_cmp++;
        if ({mm_f, mm_i} !== {ef, ei}) begin
          $display("FAIL rand_drain_%0d: got %h %h want %h %h", n_out, mm_f, mm_i, ef, ei);
          n_fail++;
        end
        n_out++;
      end
      step();
    end
    n_cmp++;
    if (n_out != 1000 || n_acc != 1000 || qf.size() != 0) begin
      $display("FAIL rand_count: got acc=%0d out=%0d pending=%0d want 1000 1000 0", n_acc, n_out, qf.size());
      n_fail++;
    end
  endtask

  initial begin
    F_IN  = mk(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'h2d26314c);
    F_OUT = mk(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'h4d7ebdf8);
    R_IN  = mk(32'hc6c6c6c6, 32'hd4d4d4d5, 32'hc6c6c6c6, 32'hd4d4d4d5);
    R_OUT = mk(32'hc6c6c6c6, 32'hd5d5d7d6, 32'hc6c6c6c6, 32'hd5d5d7d6);
    BP    = mk(32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff);
    test_reset();
    test_forward_inverse();
    test_bypass();
    test_stall_back_to_back();
    test_reset_mid_compute();
    test_random_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mix_columns_seq.md
MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

Interface
REQ-001 Parameter INVERSE, default 0: 0 = forward MixColumns, 1 = InvMixColumns (decrypt path); fixed at elaboration.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  upstream (ShiftRows output) matrix valid.
REQ-005 in_ready  output  1  block can accept a matrix this cycle.
REQ-006 in_bypass  input  1  final AES round; matrix passes through unmixed.
REQ-007 state_matrix  input  8 x [0:3][0:3]  input bytes, indexed [row][col]; column c = state_matrix[0..3][c].
REQ-008 out_valid  output  1  mixed_matrix holds a finished result.
REQ-009 out_ready  input  1  downstream (AddRoundKey) accepts result.
REQ-010 mixed_matrix  output  8 x [0:3][0:3]  result bytes, same [row][col] indexing.
REQ-011 busy  output  1  high in COMPUTE state.

Function
REQ-012 FSM states IDLE, COMPUTE, DONE; a 2-bit column counter col (0..3); one internal 4x4 byte working register.
REQ-013 Accept = in_valid && in_ready; on accept the working register loads state_matrix and col clears to 0.
REQ-014 in_ready = (IDLE) || (DONE && out_ready); in_ready is 0 in COMPUTE.
REQ-015 Accept with in_bypass=0 -> COMPUTE; with in_bypass=1 -> DONE, register holds input unchanged.
REQ-016 COMPUTE: each cycle replaces column col with its MixColumns (or InvMixColumns) transform, then col increments; after col=3 is processed -> DONE.
REQ-017 Forward transform per column (a0..a3 -> b0..b3): b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3, GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11B).
REQ-018 Inverse transform uses coefficients {0e,0b,0d,09} in the same circulant pattern; multiplication by xtime chains, no lookup tables, all results 8-bit.
REQ-019 Latency: accept at edge T -> out_valid high after edge T+4 (non-bypass), after edge T+1 (bypass).
REQ-020 out_valid = (DONE); mixed_matrix = working register, stable while out_valid && !out_ready.
REQ-021 DONE && out_ready && !in_valid -> IDLE; DONE && out_ready && in_valid -> new accept same edge (back-to-back, no bubble), next state per REQ-015.
REQ-022 in_valid while not in_ready is ignored; inputs need not be held by block.
REQ-023 in_bypass sampled only at accept; changes at other times have no effect.
REQ-024 busy = 1 exactly in COMPUTE (4 cycles per non-bypass matrix).

Reset
REQ-025 rst asserted at any time (incl. mid-COMPUTE or DONE): state -> IDLE, col -> 0, working register -> all 0x00, asynchronously.
REQ-026 During and after reset until next accept: out_valid=0, busy=0, in_ready=1, mixed_matrix all 0x00.
REQ-027 A matrix in flight at reset is discarded; no partial result emitted.

Verification
REQ-028 INVERSE=0, column 0 = db,13,53,45, cols 1..3 = f2,0a,22,5c / 01,01,01,01 / 2d,26,31,4c, in_bypass=0, out_ready=1 -> 5 cycles later columns 8e,4d,a1,bc / 9f,dc,58,9d / 01,01,01,01 / 4d,7e,bd,f8.
REQ-029 INVERSE=1, input = REQ-028 result -> output equals REQ-028 input bytes exactly.
REQ-030 in_bypass=1, arbitrary matrix -> out_valid after edge T+1, mixed_matrix identical to input, busy never asserted.
REQ-031 out_ready=0 for 10 cycles in DONE -> out_valid and mixed_matrix stable, in_ready=0, extra in_valid ignored; then out_ready=1 with in_valid=1 -> result handed off and new matrix accepted same edge.
REQ-032 rst pulsed asynchronously with col=2 in COMPUTE -> immediate IDLE, outputs per REQ-026; next matrix c6,c6,c6,c6 / d4,d4,d4,d5 columns -> c6,c6,c6,c6 / d5,d5,d7,d6, no corruption.
REQ-033 Random stream of 1000 matrices with random in_valid/out_ready/in_bypass vs. reference model -> every output matches in order, none dropped or duplicated.
